// File: rtl/ps_axi_pkg.sv
// Shared definitions for the PS-side AXI4 scratchpad slave.
// Holds the AXI response and burst encodings, the write/read FSM state
// enums, and the helper that maps a byte address onto a scratchpad word.
package ps_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef struct packed {
    logic [31:0] index;
    logic        in_range;
  } word_loc_t;

  // Word index relative to base plus an in-range flag. Addresses below base
  // wrap to a huge offset, so both bounds are tested explicitly.
  function automatic word_loc_t word_loc(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] depth);
    word_loc_t loc;
    loc.index    = (addr - base) >> 2;
    loc.in_range = (addr >= base) && (loc.index < depth);
    return loc;
  endfunction

endpackage

// File: rtl/ps_axi_scratchpad_slave_if.sv
// AXI4 bus bundle between the Zynq PS general-purpose master and the
// scratchpad slave: AW, W, B, AR and R channels.
// Modports: master (PS side, drives requests) and slave (scratchpad side).
interface ps_axi_scratchpad_slave_if #(
  parameter int ID_W = 12
);
  logic            aw_valid;
  logic            aw_ready;
  logic [31:0]     aw_addr;
  logic [7:0]      aw_len;
  logic [2:0]      aw_size;
  logic [1:0]      aw_burst;
  logic [ID_W-1:0] aw_id;

  logic            w_valid;
  logic            w_ready;
  logic [31:0]     w_data;
  logic [3:0]      w_strb;
  logic            w_last;

  logic            b_valid;
  logic            b_ready;
  logic [ID_W-1:0] b_id;
  logic [1:0]      b_resp;

  logic            ar_valid;
  logic            ar_ready;
  logic [31:0]     ar_addr;
  logic [7:0]      ar_len;
  logic [2:0]      ar_size;
  logic [1:0]      ar_burst;
  logic [ID_W-1:0] ar_id;

  logic            r_valid;
  logic            r_ready;
  logic [31:0]     r_data;
  logic [ID_W-1:0] r_id;
  logic [1:0]      r_resp;
  logic            r_last;

  modport master (
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id,
    input  ar_ready,
    input  r_valid, r_data, r_id, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id,
    output ar_ready,
    output r_valid, r_data, r_id, r_resp, r_last,
    input  r_ready
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address helper for one AXI channel.
// Ports:
//   addr      in   current beat byte address
//   size      in   AXI beat size (log2 bytes)
//   burst     in   AXI burst type
//   step      in   advance to the next beat this cycle
//   next_addr out  address of the following beat (addr when not stepping)
//   word_idx  out  scratchpad word index of addr
//   legal     out  beat may touch memory (supported burst/size, in range)
module axi_burst_addr_gen
  import ps_axi_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic [31:0]      addr,
  input  logic [2:0]       size,
  input  logic [1:0]       burst,
  input  logic             step,
  output logic [31:0]      next_addr,
  output logic [IDX_W-1:0] word_idx,
  output logic             legal
);

  word_loc_t loc;

  // NOTE: every output gets a default at the top of the block so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    loc       = word_loc(addr, BASE_ADDR, 32'(DEPTH_WORDS));
    word_idx  = IDX_W'(loc.index);
    legal     = loc.in_range && (size <= 3'd2) &&
                ((burst == BURST_FIXED) || (burst == BURST_INCR));
    next_addr = addr;
    // WRAP and reserved bursts never touch memory, so their address is moot.
    if (step && (burst == BURST_INCR)) begin
      next_addr = addr + (32'd1 << size);
    end
  end

endmodule

// File: rtl/ps_axi_scratchpad_slave.sv
// AXI4 slave terminating the PS general-purpose master in a fabric
// scratchpad. Independent write (AW/W/B) and read (AR/R) FSMs share one
// word array: one byte-masked write port and one asynchronous read port.
// Ports:
//   clock  in   single clock domain
//   reset  in   synchronous, active-high; abandons any burst in flight
//   axi    slave modport of ps_axi_scratchpad_slave_if
module ps_axi_scratchpad_slave
  import ps_axi_pkg::*;
#(
  parameter int          ID_W        = 12,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000
) (
  input logic                      clock,
  input logic                      reset,
  ps_axi_scratchpad_slave_if.slave axi
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  // ---------------------------------------------------------------- write
  wr_state_t       wr_state, wr_state_next;
  logic [31:0]     wr_addr, wr_next_addr;
  logic [7:0]      wr_len, wr_cnt;
  logic [2:0]      wr_size;
  logic [1:0]      wr_burst, wr_resp;
  logic [ID_W-1:0] wr_id;
  logic            wr_overrun;
  logic [IDX_W-1:0] wr_idx;
  logic            wr_legal, aw_hs, w_hs, b_hs, wr_en;

  assign aw_hs = axi.aw_valid && axi.aw_ready;
  assign w_hs  = axi.w_valid && axi.w_ready;
  assign b_hs  = axi.b_valid && axi.b_ready;
  // Beats past len (w_last missing) are consumed but never written.
  assign wr_en = w_hs && wr_legal && !wr_overrun;

  axi_burst_addr_gen #(.DEPTH_WORDS(DEPTH_WORDS), .BASE_ADDR(BASE_ADDR)) u_wr_gen (
    .addr(wr_addr), .size(wr_size), .burst(wr_burst), .step(w_hs),
    .next_addr(wr_next_addr), .word_idx(wr_idx), .legal(wr_legal)
  );

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) wr_state <= W_IDLE;
    else       wr_state <= wr_state_next;
  end

  always_comb begin
    wr_state_next = wr_state;
    unique case (wr_state)
      W_IDLE:  if (aw_hs) wr_state_next = W_DATA;
      W_DATA:  if (w_hs && axi.w_last) wr_state_next = W_RESP;
      W_RESP:  if (b_hs) wr_state_next = W_IDLE;
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    axi.aw_ready = 1'b0;
    axi.w_ready  = 1'b0;
    axi.b_valid  = 1'b0;
    axi.b_id     = '0;
    axi.b_resp   = RESP_OKAY;
    if (!reset) begin
      unique case (wr_state)
        W_IDLE: axi.aw_ready = 1'b1;
        W_DATA: axi.w_ready  = 1'b1;
        W_RESP: begin
          axi.b_valid = 1'b1;
          axi.b_id    = wr_id;
          axi.b_resp  = wr_resp;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_addr    <= '0;
      wr_len     <= '0;
      wr_cnt     <= '0;
      wr_size    <= '0;
      wr_burst   <= '0;
      wr_id      <= '0;
      wr_resp    <= RESP_OKAY;
      wr_overrun <= 1'b0;
    end else if (aw_hs) begin
      wr_addr    <= axi.aw_addr;
      wr_len     <= axi.aw_len;
      wr_size    <= axi.aw_size;
      wr_burst   <= axi.aw_burst;
      wr_id      <= axi.aw_id;
      wr_cnt     <= '0;
      wr_resp    <= RESP_OKAY;
      wr_overrun <= 1'b0;
    end else if (w_hs) begin
      wr_addr <= wr_next_addr;
      if (!wr_overrun && !wr_legal) wr_resp <= RESP_SLVERR;
      if (axi.w_last && (wr_cnt != wr_len)) wr_resp <= RESP_SLVERR;
      if (!axi.w_last) begin
        // Beat len came without w_last: keep draining until w_last shows up.
        if (wr_cnt == wr_len) begin
          wr_overrun <= 1'b1;
          wr_resp    <= RESP_SLVERR;
        end else begin
          wr_cnt <= wr_cnt + 8'd1;
        end
      end
    end
  end

  // NOTE: the scratchpad array has no reset; contents survive reset and
  // staying reset-free lets it map onto RAM resources.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (axi.w_strb[b]) mem[wr_idx][8*b +: 8] <= axi.w_data[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  rd_state_t       rd_state, rd_state_next;
  logic [31:0]     rd_addr, rd_addr_sel, rd_next_addr, rd_data;
  logic [7:0]      rd_len, rd_cnt;
  logic [2:0]      rd_size, rd_size_sel;
  logic [1:0]      rd_burst, rd_burst_sel, rd_resp;
  logic [ID_W-1:0] rd_id;
  logic [IDX_W-1:0] rd_idx;
  logic            rd_legal, rd_last, ar_hs, r_hs, rd_launch;

  assign ar_hs   = axi.ar_valid && axi.ar_ready;
  assign r_hs    = axi.r_valid && axi.r_ready;
  assign rd_last = (rd_cnt == rd_len);
  assign rd_launch = ar_hs || (r_hs && !rd_last);

  // rd_addr holds the address of the next beat to launch; while idle the
  // first beat comes straight from the AR channel so it launches on the
  // handshake edge.
  assign rd_addr_sel  = (rd_state == R_IDLE) ? axi.ar_addr  : rd_addr;
  assign rd_size_sel  = (rd_state == R_IDLE) ? axi.ar_size  : rd_size;
  assign rd_burst_sel = (rd_state == R_IDLE) ? axi.ar_burst : rd_burst;

  axi_burst_addr_gen #(.DEPTH_WORDS(DEPTH_WORDS), .BASE_ADDR(BASE_ADDR)) u_rd_gen (
    .addr(rd_addr_sel), .size(rd_size_sel), .burst(rd_burst_sel), .step(rd_launch),
    .next_addr(rd_next_addr), .word_idx(rd_idx), .legal(rd_legal)
  );

  always_ff @(posedge clock) begin
    if (reset) rd_state <= R_IDLE;
    else       rd_state <= rd_state_next;
  end

  always_comb begin
    rd_state_next = rd_state;
    unique case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_next = R_DATA;
      R_DATA:  if (r_hs && rd_last) rd_state_next = R_IDLE;
      default: rd_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    axi.ar_ready = 1'b0;
    axi.r_valid  = 1'b0;
    axi.r_data   = '0;
    axi.r_id     = '0;
    axi.r_resp   = RESP_OKAY;
    axi.r_last   = 1'b0;
    if (!reset) begin
      unique case (rd_state)
        R_IDLE: axi.ar_ready = 1'b1;
        R_DATA: begin
          axi.r_valid = 1'b1;
          axi.r_data  = rd_data;
          axi.r_id    = rd_id;
          axi.r_resp  = rd_resp;
          axi.r_last  = rd_last;
        end
        default: ;
      endcase
    end
  end

  // Memory is sampled at the launch edge, so a same-cycle write to the
  // same word is not yet visible here.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_cnt   <= '0;
      rd_size  <= '0;
      rd_burst <= '0;
      rd_id    <= '0;
      rd_data  <= '0;
      rd_resp  <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        rd_len   <= axi.ar_len;
        rd_size  <= axi.ar_size;
        rd_burst <= axi.ar_burst;
        rd_id    <= axi.ar_id;
        rd_cnt   <= '0;
      end else if (r_hs) begin
        rd_cnt <= rd_cnt + 8'd1;
      end
      if (rd_launch) begin
        rd_addr <= rd_next_addr;
        rd_data <= rd_legal ? mem[rd_idx] : 32'h0;
        rd_resp <= rd_legal ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_ps_axi_scratchpad_slave.sv
// Directed bench for ps_axi_scratchpad_slave: a word-level memory model
// predicts every B response and R beat; a negedge monitor compares the DUT
// against those predictions, and literal values pin the model itself.
module tb_ps_axi_scratchpad_slave;
  import ps_axi_pkg::*;

  localparam int          ID_W  = 12;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h4000_0000;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [11:0] id;
  } r_exp_t;

  typedef struct {
    logic [11:0] id;
    logic [1:0]  resp;
  } b_exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ps_axi_scratchpad_slave_if #(.ID_W(ID_W)) axi ();

  ps_axi_scratchpad_slave #(.ID_W(ID_W), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock(clock),
    .reset(reset),
    .axi(axi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl_mem [int];
  r_exp_t      r_exp [$];
  b_exp_t      b_exp [$];
  logic [31:0] rcv_data [$];
  logic [1:0]  rcv_resp [$];
  logic [1:0]  last_b_resp;
  logic [11:0] last_b_id;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Model: beat k of a burst sits at start + k*stride (FIXED stride 0).
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] stride;
    stride = (burst == BURST_FIXED) ? 32'd0 : (32'd1 << size);
    return a + 32'(k) * stride;
  endfunction

  function automatic bit beat_ok(input logic [31:0] ba, input logic [2:0] size, input logic [1:0] burst);
    if (burst > BURST_INCR || size > 3'd2) return 1'b0;
    if (ba < BASE) return 1'b0;
    return ((ba - BASE) >> 2) < DEPTH;
  endfunction

  // Compare process: every cycle an R or B beat is presented.
  always @(negedge clock) begin
    if (reset) begin
      r_exp.delete();
      b_exp.delete();
    end else begin
      if (axi.r_valid) begin
        if (r_exp.size() == 0) check("r_unexpected", 32'(axi.r_valid), 32'd0);
        else begin
          check("r_data", axi.r_data, r_exp[0].data);
          check("r_resp", 32'(axi.r_resp), 32'(r_exp[0].resp));
          check("r_last", 32'(axi.r_last), 32'(r_exp[0].last));
          check("r_id", 32'(axi.r_id), 32'(r_exp[0].id));
          if (axi.r_ready) begin
            rcv_data.push_back(axi.r_data);
            rcv_resp.push_back(axi.r_resp);
            void'(r_exp.pop_front());
          end
        end
      end
      if (axi.b_valid) begin
        if (b_exp.size() == 0) check("b_unexpected", 32'(axi.b_valid), 32'd0);
        else begin
          check("b_id", 32'(axi.b_id), 32'(b_exp[0].id));
          check("b_resp", 32'(axi.b_resp), 32'(b_exp[0].resp));
          if (axi.b_ready) begin
            last_b_resp = axi.b_resp;
            last_b_id   = axi.b_id;
            void'(b_exp.pop_front());
          end
        end
      end
    end
  end

  // n beats are sent with data seed+k; w_last rides on beat n-1.
  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [11:0] id, input int n,
                             input logic [31:0] seed, input logic [3:0] strb);
    b_exp_t      e;
    logic [31:0] ba, d, wd;
    int          idx;
    logic        got;
    e.id   = id;
    e.resp = (n - 1 != int'(len)) ? RESP_SLVERR : RESP_OKAY;
    for (int k = 0; k < n && k <= int'(len); k++) begin
      ba = beat_addr(addr, k, size, burst);
      if (!beat_ok(ba, size, burst)) e.resp = RESP_SLVERR;
      else begin
        idx = int'((ba - BASE) >> 2);
        d   = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
        wd  = seed + 32'(k);
        for (int bi = 0; bi < 4; bi++) if (strb[bi]) d[8*bi +: 8] = wd[8*bi +: 8];
        mdl_mem[idx] = d;
      end
    end
    b_exp.push_back(e);

    axi.aw_addr = addr; axi.aw_len = len; axi.aw_size = size;
    axi.aw_burst = burst; axi.aw_id = id; axi.aw_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin @(negedge clock); got = axi.aw_ready; end
    check("aw_handshake", 32'(got), 32'd1);
    @(posedge clock); #1;
    axi.aw_valid = 1'b0;

    for (int k = 0; k < n; k++) begin
      axi.w_data = seed + 32'(k); axi.w_strb = strb;
      axi.w_last = (k == n - 1); axi.w_valid = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin @(negedge clock); got = axi.w_ready; end
      check("w_handshake", 32'(got), 32'd1);
      @(posedge clock); #1;
    end
    axi.w_valid = 1'b0; axi.w_last = 1'b0;

    for (int c = 0; c < 100 && b_exp.size() > 0; c++) begin
      @(negedge clock);
      if (axi.b_valid) check("aw_ready_in_resp", 32'(axi.aw_ready), 32'd0);
    end
    check("b_done", 32'(b_exp.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  // Predicts all beats, performs the AR handshake, checks first-beat latency.
  task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [11:0] id);
    r_exp_t      e;
    logic [31:0] ba;
    int          idx;
    logic        got;
    for (int k = 0; k <= int'(len); k++) begin
      ba     = beat_addr(addr, k, size, burst);
      e.last = (k == int'(len));
      e.id   = id;
      if (beat_ok(ba, size, burst)) begin
        idx    = int'((ba - BASE) >> 2);
        e.data = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
        e.resp = RESP_OKAY;
      end else begin
        e.data = 32'h0;
        e.resp = RESP_SLVERR;
      end
      r_exp.push_back(e);
    end
    rcv_data.delete();
    rcv_resp.delete();
    axi.r_ready = 1'b1;
    axi.ar_addr = addr; axi.ar_len = len; axi.ar_size = size;
    axi.ar_burst = burst; axi.ar_id = id; axi.ar_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin @(negedge clock); got = axi.ar_ready; end
    check("ar_handshake", 32'(got), 32'd1);
    @(posedge clock); #1;
    axi.ar_valid = 1'b0;
    @(negedge clock);
    check("r_first_latency", 32'(axi.r_valid), 32'd1);
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [11:0] id, input bit toggle);
    issue_ar(addr, len, size, burst, id);
    for (int c = 0; c < 300 && r_exp.size() > 0; c++) begin
      @(posedge clock); #1;
      if (toggle) axi.r_ready = ~axi.r_ready;
    end
    check("r_done", 32'(r_exp.size()), 32'd0);
    axi.r_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    axi.aw_valid = 0; axi.aw_addr = 0; axi.aw_len = 0; axi.aw_size = 0; axi.aw_burst = 0; axi.aw_id = 0;
    axi.w_valid = 0; axi.w_data = 0; axi.w_strb = 0; axi.w_last = 0; axi.b_ready = 1;
    axi.ar_valid = 0; axi.ar_addr = 0; axi.ar_len = 0; axi.ar_size = 0; axi.ar_burst = 0; axi.ar_id = 0;
    axi.r_ready = 1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_aw_ready", 32'(axi.aw_ready), 32'd0);
    check("rst_ar_ready", 32'(axi.ar_ready), 32'd0);
    check("rst_w_ready", 32'(axi.w_ready), 32'd0);
    check("rst_b_valid", 32'(axi.b_valid), 32'd0);
    check("rst_r_valid", 32'(axi.r_valid), 32'd0);
    check("rst_r_data", axi.r_data, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_aw_ready", 32'(axi.aw_ready), 32'd1);
    check("post_rst_ar_ready", 32'(axi.ar_ready), 32'd1);
    @(posedge clock); #1;

    // Single write then read.
    write_burst(32'h4000_0010, 8'd0, 3'd2, BURST_INCR, 12'h5A3, 1, 32'hDEAD_BEEF, 4'hF);
    check("t1_b_resp", 32'(last_b_resp), 32'(RESP_OKAY));
    check("t1_b_id", 32'(last_b_id), 32'h5A3);
    read_burst(32'h4000_0010, 8'd0, 3'd2, BURST_INCR, 12'h5A3, 1'b0);
    check("t1_r_data", rcv_data[0], 32'hDEAD_BEEF);

    // INCR burst, read back under r_ready toggling.
    write_burst(32'h4000_0100, 8'd3, 3'd2, BURST_INCR, 12'h011, 4, 32'd1, 4'hF);
    read_burst(32'h4000_0100, 8'd3, 3'd2, BURST_INCR, 12'h022, 1'b1);
    check("t2_beats", 32'(rcv_data.size()), 32'd4);
    for (int k = 0; k < 4; k++) check("t2_data", rcv_data[k], 32'(k + 1));

    // Partial strobe over a preloaded word.
    write_burst(32'h4000_0200, 8'd0, 3'd2, BURST_INCR, 12'h033, 1, 32'h1122_3344, 4'hF);
    write_burst(32'h4000_0200, 8'd0, 3'd2, BURST_INCR, 12'h034, 1, 32'hAABB_CCDD, 4'b0101);
    read_burst(32'h4000_0200, 8'd0, 3'd2, BURST_INCR, 12'h035, 1'b0);
    check("t3_strobe", rcv_data[0], 32'h11BB_33DD);

    // Crossing the top of the scratchpad.
    write_burst(BASE + 32'(4 * (DEPTH - 1)), 8'd1, 3'd2, BURST_INCR, 12'h044, 2, 32'hCAFE_0001, 4'hF);
    check("t4_b_resp", 32'(last_b_resp), 32'(RESP_SLVERR));
    read_burst(BASE + 32'(4 * (DEPTH - 1)), 8'd1, 3'd2, BURST_INCR, 12'h045, 1'b0);
    check("t4_beat0_data", rcv_data[0], 32'hCAFE_0001);
    check("t4_beat0_resp", 32'(rcv_resp[0]), 32'(RESP_OKAY));
    check("t4_beat1_data", rcv_data[1], 32'h0);
    check("t4_beat1_resp", 32'(rcv_resp[1]), 32'(RESP_SLVERR));

    // WRAP: error, memory untouched.
    write_burst(32'h4000_0100, 8'd1, 3'd2, BURST_WRAP, 12'h055, 2, 32'h0000_BAD0, 4'hF);
    check("t5_b_resp", 32'(last_b_resp), 32'(RESP_SLVERR));
    read_burst(32'h4000_0100, 8'd3, 3'd2, BURST_INCR, 12'h056, 1'b0);
    check("t5_unchanged", rcv_data[1], 32'd2);
    read_burst(32'h4000_0100, 8'd1, 3'd2, BURST_WRAP, 12'h057, 1'b0);
    check("t5_wrap_read_resp", 32'(rcv_resp[0]), 32'(RESP_SLVERR));

    // Early w_last on beat 1 of len=3.
    write_burst(32'h4000_0300, 8'd3, 3'd2, BURST_INCR, 12'h066, 2, 32'h300, 4'hF);
    check("t6_b_resp", 32'(last_b_resp), 32'(RESP_SLVERR));
    @(negedge clock);
    check("t6_back_idle", 32'(axi.aw_ready), 32'd1);
    @(posedge clock); #1;
    read_burst(32'h4000_0300, 8'd1, 3'd2, BURST_INCR, 12'h067, 1'b0);

    // size=3 is unsupported on both channels.
    write_burst(32'h4000_0100, 8'd0, 3'd3, BURST_INCR, 12'h077, 1, 32'hEE, 4'hF);
    check("t7_b_resp", 32'(last_b_resp), 32'(RESP_SLVERR));
    read_burst(32'h4000_0100, 8'd0, 3'd3, BURST_INCR, 12'h078, 1'b0);
    read_burst(32'h4000_0100, 8'd0, 3'd2, BURST_INCR, 12'h079, 1'b0);
    check("t7_unchanged", rcv_data[0], 32'd1);

    // Missing w_last: extra beat drained but not stored.
    write_burst(32'h4000_0408, 8'd0, 3'd2, BURST_INCR, 12'h088, 1, 32'h5555, 4'hF);
    write_burst(32'h4000_0400, 8'd1, 3'd2, BURST_INCR, 12'h089, 3, 32'h400, 4'hF);
    check("t8_b_resp", 32'(last_b_resp), 32'(RESP_SLVERR));
    read_burst(32'h4000_0400, 8'd2, 3'd2, BURST_INCR, 12'h08A, 1'b0);
    check("t8_extra_dropped", rcv_data[2], 32'h5555);

    // FIXED burst keeps hitting one word.
    write_burst(32'h4000_0500, 8'd2, 3'd2, BURST_FIXED, 12'h099, 3, 32'h500, 4'hF);
    check("t9_b_resp", 32'(last_b_resp), 32'(RESP_OKAY));
    read_burst(32'h4000_0500, 8'd1, 3'd2, BURST_FIXED, 12'h09A, 1'b0);
    check("t9_fixed_data", rcv_data[1], 32'h502);

    // Starting below BASE: first beat rejected, second lands on word 0.
    write_burst(32'h3FFF_FFFC, 8'd1, 3'd2, BURST_INCR, 12'h0A0, 2, 32'h900, 4'hF);
    check("t10_b_resp", 32'(last_b_resp), 32'(RESP_SLVERR));
    read_burst(32'h3FFF_FFFC, 8'd1, 3'd2, BURST_INCR, 12'h0A1, 1'b0);
    check("t10_word0", rcv_data[1], 32'h901);

    // 32-bit address wrap is simply out of range.
    read_burst(32'hFFFF_FFFC, 8'd1, 3'd2, BURST_INCR, 12'h0A2, 1'b0);

    // Reset in the middle of a len=7 read.
    write_burst(32'h4000_0600, 8'd7, 3'd2, BURST_INCR, 12'h0B0, 8, 32'h100, 4'hF);
    issue_ar(32'h4000_0600, 8'd7, 3'd2, BURST_INCR, 12'h0B1);
    @(posedge clock);
    @(posedge clock); #1;
    check("t11_beats_before_rst", 32'(rcv_data.size()), 32'd2);
    check("t11_beat2_valid", 32'(axi.r_valid), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("t11_r_valid_rst", 32'(axi.r_valid), 32'd0);
    check("t11_ar_ready_rst", 32'(axi.ar_ready), 32'd0);
    @(posedge clock); #1;
    check("t11_r_valid_next", 32'(axi.r_valid), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("t11_ar_ready_after", 32'(axi.ar_ready), 32'd1);
    check("t11_no_r_after", 32'(axi.r_valid), 32'd0);
    @(posedge clock); #1;
    read_burst(32'h4000_0600, 8'd7, 3'd2, BURST_INCR, 12'h0B2, 1'b0);
    check("t11_reread_beat2", rcv_data[2], 32'h102);
    check("t11_reread_beat7", rcv_data[7], 32'h107);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
